regfile_wb: RTL

Write-back stage and operand register file for the 16-bit datapath. Holds four 16-bit general registers and the carry flag. Supplies the ALU operands (`inreg1`, `inreg2`, `carryin`) from the `rm`/`rn` fields of the current instruction. Captures the ALU result (`aluout`, `carryout`) through a one-entry write-back pipeline register. Full bypass forwarding lets back-to-back dependent instructions see the pending result without stalling.

---
 rtl/regfile_wb.sv | 88 ++++++++
 1 files changed

// File: rtl/regfile_wb.sv
// Write-back stage and 4x16 operand register file with carry flag and full bypass forwarding.
// Result is forwarded one cycle after capture and committed one edge later; there are no stalls or back-pressure.
module regfile_wb #(
  parameter int DW   = 16,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   instr,
  input  logic          valid,
  input  logic [DW-1:0] aluout,
  input  logic          carryout,
  input  logic          carryen,
  input  logic          wenout,
  output logic [DW-1:0] inreg1,
  output logic [DW-1:0] inreg2,
  output logic          carryin,
  output logic          wb_valid,
  output logic [1:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  input  logic [1:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);

  logic [1:0] rd, rm, rn;
  assign rd = instr[7:6];
  assign rm = instr[5:4];
  assign rn = instr[3:2];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[15:8], instr[1:0]};

  logic [DW-1:0] reg_q [NREG];
  logic [DW-1:0] reg_d [NREG];
  logic          c_q, c_d;
  logic          wb_valid_q, wb_valid_d;
  logic [1:0]    wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          pc_valid_q, pc_valid_d;
  logic          pc_data_q, pc_data_d;

  // Capture of the new entry and commit of the old one happen on the same edge.
  always_comb begin
    wb_valid_d = valid && wenout;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (wb_valid_d) begin
      wb_rd_d   = rd;
      wb_data_d = aluout;
    end
    pc_valid_d = valid && carryen;
    pc_data_d  = pc_data_q;
    if (pc_valid_d) pc_data_d = carryout;

    for (int i = 0; i < NREG; i++) reg_d[i] = reg_q[i];
    if (wb_valid_q) reg_d[wb_rd_q] = wb_data_q;
    c_d = pc_valid_q ? pc_data_q : c_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
      c_q        <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 2'd0;
      wb_data_q  <= '0;
      pc_valid_q <= 1'b0;
      pc_data_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= reg_d[i];
      c_q        <= c_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      pc_valid_q <= pc_valid_d;
      pc_data_q  <= pc_data_d;
    end
  end

  assign inreg1   = (wb_valid_q && wb_rd_q == rm) ? wb_data_q : reg_q[rm];
  assign inreg2   = (wb_valid_q && wb_rd_q == rn) ? wb_data_q : reg_q[rn];
  assign carryin  = pc_valid_q ? pc_data_q : c_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign dbg_data = reg_q[dbg_sel];

endmodule
